// File: rtl/i2c_rx_deserializer.sv
// rtl/i2c_rx_deserializer.sv - I2C receive deserializer: SDA sync, bit framing, word FIFO
// Optional 3-sample SDA majority filter enabled by RX_GLITCH_FILTER_EN.
module i2c_rx_deserializer #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          sda_in,
  input  logic                          scl_rise,
  input  logic                          rx_enable,
  input  logic                          frame_clear,
  input  logic                          ovr_clear,
  output logic [DATA_W-1:0]             rx_data,
  output logic [$clog2(DATA_W)-1:0]     bit_count,
  output logic                          byte_valid,
  output logic [DATA_W-1:0]             byte_data,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun
);
  localparam int CW = $clog2(DATA_W);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sda_s, sda_bit;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sda_in};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign sda_s = sync_q[SYNC_STAGES-1];

`ifdef RX_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;
  logic       filt_q, filt_d;

  // Majority of current and two previous samples; a lone 1-clk pulse never wins.
  always_comb begin
    hist_d = {hist_q[0], sda_s};
    filt_d = (sda_s & hist_q[0]) | (sda_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign sda_bit = filt_q;
`else
  assign sda_bit = sda_s;
`endif

  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              shift_en, word_done;

  assign shift_en  = scl_rise & rx_enable & ~frame_clear;
  assign word_done = shift_en & (bit_cnt_q == CW'(DATA_W - 1));

  always_comb begin
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    if (frame_clear) begin
      bit_cnt_d = '0;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) rx_data_d = {rx_data_q[DATA_W-2:0], sda_bit};
      else                rx_data_d = {sda_bit, rx_data_q[DATA_W-1:1]};
      bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
    end
  end

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovr_q, ovr_d;
  logic              pop, full, drop, wr;

  assign pop  = byte_valid & byte_ready;
  assign full = (level_q == LW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so only an unpopped full FIFO drops.
  assign drop = word_done & full & ~pop;
  assign wr   = word_done & ~drop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr) begin
      mem_d[wr_ptr_q] = rx_data_d;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovr_d = drop ? 1'b1 : (ovr_clear ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data_q <= '1;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovr_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovr_q     <= ovr_d;
      mem_q     <= mem_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign bit_count  = bit_cnt_q;
  assign byte_valid = (level_q != '0);
  assign byte_data  = byte_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_i2c_rx_deserializer.sv
// tb/tb_i2c_rx_deserializer.sv - directed table-driven bench for i2c_rx_deserializer
// Drives an MSB-first and an LSB-first instance from the same stimulus.
module tb_i2c_rx_deserializer;
  logic clk = 1'b0;
  logic n_rst, sda_in, scl_rise, rx_enable, frame_clear, ovr_clear, byte_ready;

  logic [7:0] m_rx_data, m_byte_data, l_rx_data, l_byte_data;
  logic [2:0] m_bit_count, l_bit_count;
  logic [2:0] m_level, l_level;
  logic       m_valid, l_valid, m_ovr, l_ovr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  i2c_rx_deserializer #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_msb (
    .clk(clk), .n_rst(n_rst), .sda_in(sda_in), .scl_rise(scl_rise), .rx_enable(rx_enable),
    .frame_clear(frame_clear), .ovr_clear(ovr_clear), .rx_data(m_rx_data),
    .bit_count(m_bit_count), .byte_valid(m_valid), .byte_data(m_byte_data),
    .byte_ready(byte_ready), .fifo_level(m_level), .overrun(m_ovr));

  i2c_rx_deserializer #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(0), .FIFO_DEPTH(4)) u_lsb (
    .clk(clk), .n_rst(n_rst), .sda_in(sda_in), .scl_rise(scl_rise), .rx_enable(rx_enable),
    .frame_clear(frame_clear), .ovr_clear(ovr_clear), .rx_data(l_rx_data),
    .bit_count(l_bit_count), .byte_valid(l_valid), .byte_data(l_byte_data),
    .byte_ready(byte_ready), .fifo_level(l_level), .overrun(l_ovr));

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit pop_last);
    for (int i = 7; i >= 0; i--) begin
      sda_in = w[i];
      repeat (5) tick();
      scl_rise = 1'b1;
      if (i == 0 && pop_last) byte_ready = 1'b1;
      tick();
      scl_rise   = 1'b0;
      byte_ready = 1'b0;
    end
  endtask

  task automatic pop_one();
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_data"}, m_rx_data, 8'hFF);
    check({tag, "_rx_data_lsb"}, l_rx_data, 8'hFF);
    check({tag, "_bit_count"}, m_bit_count, 0);
    check({tag, "_byte_valid"}, m_valid, 0);
    check({tag, "_byte_data"}, m_byte_data, 0);
    check({tag, "_fifo_level"}, m_level, 0);
    check({tag, "_overrun"}, m_ovr, 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h01, 8'h01, 8'h80};
    vecs[2] = '{8'h3C, 8'h3C, 8'h3C};
    vecs[3] = '{8'hF0, 8'hF0, 8'h0F};
    vecs[4] = '{8'h96, 8'h96, 8'h69};

    n_rst = 1'b0; sda_in = 1'b1; scl_rise = 1'b0; rx_enable = 1'b1;
    frame_clear = 1'b0; ovr_clear = 1'b0; byte_ready = 1'b0;
    repeat (3) tick();
    check_reset_state("in_reset");
    n_rst = 1'b1;
    tick();
    check_reset_state("after_reset");

    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].word, 1'b0);
      check($sformatf("vec%0d_valid", v), m_valid, 1);
      check($sformatf("vec%0d_level", v), m_level, 1);
      check($sformatf("vec%0d_msb_data", v), m_byte_data, vecs[v].exp_msb);
      check($sformatf("vec%0d_lsb_data", v), l_byte_data, vecs[v].exp_lsb);
      check($sformatf("vec%0d_bit_count", v), m_bit_count, 0);
      pop_one();
      check($sformatf("vec%0d_level_after_pop", v), m_level, 0);
      check($sformatf("vec%0d_valid_after_pop", v), l_valid, 0);
    end

    // Overrun: five words into a depth-4 FIFO with no consumer.
    for (int k = 1; k <= 5; k++) send_word(8'(k * 8'h11), 1'b0);
    check("ovr_flag", m_ovr, 1);
    check("ovr_flag_lsb", l_ovr, 1);
    check("ovr_level", m_level, 4);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovr_drain%0d", k), m_byte_data, 8'(k * 8'h11));
      pop_one();
    end
    check("ovr_empty", m_valid, 0);
    check("ovr_sticky", m_ovr, 1);
    pop_one();
    check("pop_empty_level", m_level, 0);
    ovr_clear = 1'b1;
    tick();
    ovr_clear = 1'b0;
    check("ovr_cleared", m_ovr, 0);

    // Push and pop on the same edge while full.
    for (int k = 1; k <= 4; k++) send_word(8'(k * 8'h11), 1'b0);
    send_word(8'h55, 1'b1);
    check("fullpp_level", m_level, 4);
    check("fullpp_ovr", m_ovr, 0);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("fullpp_drain%0d", k), m_byte_data, 8'(k * 8'h11));
      pop_one();
    end
    check("fullpp_empty", m_level, 0);

    // Partial word discarded by frame_clear, which beats a coincident strobe.
    sda_in = 1'b1; repeat (5) tick(); scl_rise = 1'b1; tick(); scl_rise = 1'b0;
    sda_in = 1'b0; repeat (5) tick(); scl_rise = 1'b1; tick(); scl_rise = 1'b0;
    sda_in = 1'b1; repeat (5) tick(); scl_rise = 1'b1; tick(); scl_rise = 1'b0;
    check("fc_partial_data", m_rx_data, 8'hAD);
    check("fc_partial_count", m_bit_count, 3);
    sda_in = 1'b0; repeat (5) tick();
    scl_rise = 1'b1; frame_clear = 1'b1;
    tick();
    scl_rise = 1'b0; frame_clear = 1'b0;
    check("fc_count", m_bit_count, 0);
    check("fc_count_lsb", l_bit_count, 0);
    check("fc_hold_data", m_rx_data, 8'hAD);
    check("fc_no_push", m_level, 0);
    send_word(8'h3C, 1'b0);
    check("fc_next_word", m_byte_data, 8'h3C);
    check("fc_next_level", m_level, 1);
    pop_one();

    // Strobes while disabled must not shift or count.
    rx_enable = 1'b0; sda_in = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 3; k++) begin
      scl_rise = 1'b1; tick(); scl_rise = 1'b0; tick();
    end
    rx_enable = 1'b1;
    check("dis_rx_data", m_rx_data, 8'h3C);
    check("dis_rx_data_lsb", l_rx_data, 8'h3C);
    check("dis_bit_count", m_bit_count, 0);

`ifdef RX_GLITCH_FILTER_EN
    sda_in = 1'b1; repeat (6) tick();
    sda_in = 1'b0; tick();
    sda_in = 1'b1;
    scl_rise = 1'b1;
    repeat (6) tick();
    scl_rise = 1'b0;
    check("glitch_rx_data", m_rx_data, 8'h3F);
    check("glitch_bit_count", m_bit_count, 6);
    frame_clear = 1'b1; tick(); frame_clear = 1'b0;
    check("glitch_clear", m_bit_count, 0);
`endif

    // Asynchronous reset with a word buffered and a partial word in flight.
    send_word(8'h5A, 1'b0);
    sda_in = 1'b0; repeat (5) tick(); scl_rise = 1'b1; tick(); scl_rise = 1'b0;
    check("pre_rst_level", m_level, 1);
    check("pre_rst_count", m_bit_count, 1);
    n_rst = 1'b0;
    #1;
    check_reset_state("async_rst");
    tick();
    n_rst = 1'b1;
    tick();
    check_reset_state("post_async_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
